universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: number of bits in the shift register; SHALL be >= 2.
REQ-002 Parameter LSB_FIRST, default 0: serial bit order; 0 = MSB-first, 1 = LSB-first.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_mode  input  2  operation select: 2'b00 HOLD, 2'b01 SHIFT_IN, 2'b10 LOAD, 2'b11 SHIFT_OUT.
REQ-006 i_serial  input  1  serial data bit, sampled in SHIFT_IN.
REQ-007 i_parallel  input  WIDTH  parallel word, sampled in LOAD.
REQ-008 o_serial  output  1  current serial output bit, combinational from the register.
REQ-009 o_parallel  output  WIDTH  register contents.
REQ-010 o_word_valid  output  1  registered one-cycle pulse: a full word has been shifted in.

Function
REQ-011 HOLD SHALL keep the register, bit counter and o_word_valid source unchanged; o_word_valid SHALL be 0 in the following cycle.
REQ-012 SHIFT_IN with LSB_FIRST=0 SHALL set reg <= {reg[WIDTH-2:0], i_serial}.
REQ-013 SHIFT_IN with LSB_FIRST=1 SHALL set reg <= {i_serial, reg[WIDTH-1:1]}.
REQ-014 LOAD SHALL set reg <= i_parallel and clear the bit counter.
REQ-015 SHIFT_OUT with LSB_FIRST=0 SHALL set reg <= {reg[WIDTH-2:0], 1'b0}; with LSB_FIRST=1 it SHALL set reg <= {1'b0, reg[WIDTH-1:1]}; the bit counter SHALL be cleared.
REQ-016 o_serial SHALL equal reg[WIDTH-1] when LSB_FIRST=0 and reg[0] when LSB_FIRST=1, so the first serial-out bit is visible before the first SHIFT_OUT edge.
REQ-017 The bit counter SHALL range 0..WIDTH-1, be $clog2(WIDTH) bits wide, and increment by 1 on each SHIFT_IN edge.
REQ-018 On a SHIFT_IN edge with counter == WIDTH-1, the counter SHALL wrap to 0 and o_word_valid SHALL be 1 for exactly the next cycle.
REQ-019 While o_word_valid is 1, o_parallel SHALL hold the completed word.
REQ-020 o_word_valid SHALL be 0 in every cycle not following a wrapping SHIFT_IN edge.
REQ-021 Back-to-back words SHALL be supported: continuous SHIFT_IN produces one o_word_valid pulse every WIDTH cycles with no dead cycle.
REQ-022 HOLD cycles between SHIFT_IN bits SHALL NOT advance the counter; a word split by HOLD SHALL still complete after the WIDTH-th shifted bit.
REQ-023 LOAD or SHIFT_OUT in the middle of a partial word SHALL discard the partial count; the next complete word requires WIDTH further SHIFT_IN edges.
REQ-024 o_parallel SHALL be driven directly from the register with zero added latency: the new value is visible in the cycle after the edge.

Reset
REQ-025 When rst=1 at a rising edge, the register, bit counter and o_word_valid SHALL clear to 0, overriding any i_mode.
REQ-026 After reset o_parallel SHALL be 0, o_serial 0 and o_word_valid 0.
REQ-027 Reset mid-word SHALL discard the partial count; the first word after reset requires WIDTH SHIFT_IN edges.
REQ-028 i_mode, i_serial and i_parallel SHALL be ignored while rst=1.

Verification (WIDTH=8)
REQ-029 rst=1 for 2 cycles, mode SHIFT_IN, i_serial=1 -> o_parallel=8'h00, o_serial=0, o_word_valid=0.
REQ-030 LSB_FIRST=0: SHIFT_IN bits 1,0,1,1,0,0,1,1 on 8 consecutive edges -> o_parallel=8'hB3 and o_word_valid=1 for exactly the cycle after the 8th edge; then 8 more bits of 8'h5A -> second pulse 8 cycles later, o_parallel=8'h5A.
REQ-031 LSB_FIRST=1: SHIFT_IN bits 1,1,0,0,1,1,0,1 -> o_parallel=8'hB3 with one o_word_valid pulse.
REQ-032 LOAD 8'hA5, then 8 SHIFT_OUT edges -> o_serial sequence 1,0,1,0,0,1,0,1 (LSB_FIRST=0); o_parallel=8'h00 afterwards; o_word_valid stays 0 throughout.
REQ-033 SHIFT_IN 5 bits, HOLD 3 cycles, SHIFT_IN 3 bits -> exactly one pulse, after the 8th shifted bit; o_parallel stable during HOLD.
REQ-034 SHIFT_IN 4 bits, then LOAD 8'h3C (or rst=1 for one cycle), then SHIFT_IN 7 bits -> no pulse; the 8th SHIFT_IN edge produces the pulse.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, serial shift-in with word framing, parallel load, serial shift-out.
// o_parallel/o_serial reflect the register directly; o_word_valid pulses the cycle after the WIDTH-th shifted-in bit.
module universal_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_mode,
    input  logic             i_serial,
    input  logic [WIDTH-1:0] i_parallel,
    output logic             o_serial,
    output logic [WIDTH-1:0] o_parallel,
    output logic             o_word_valid
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] MODE_HOLD      = 2'b00;
    localparam logic [1:0] MODE_SHIFT_IN  = 2'b01;
    localparam logic [1:0] MODE_LOAD      = 2'b10;
    localparam logic [1:0] MODE_SHIFT_OUT = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic             word_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            cnt_q      <= '0;
            word_vld_q <= 1'b0;
        end else begin
            word_vld_q <= 1'b0;
            case (i_mode)
                MODE_SHIFT_IN: begin
                    if (LSB_FIRST) begin
                        data_q <= {i_serial, data_q[WIDTH-1:1]};
                    end else begin
                        data_q <= {data_q[WIDTH-2:0], i_serial};
                    end
                    // Wrap and flag the completed word on the same edge so words run back-to-back.
                    if (cnt_q == CNT_LAST) begin
                        cnt_q      <= '0;
                        word_vld_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                MODE_LOAD: begin
                    data_q <= i_parallel;
                    cnt_q  <= '0;
                end
                MODE_SHIFT_OUT: begin
                    if (LSB_FIRST) begin
                        data_q <= {1'b0, data_q[WIDTH-1:1]};
                    end else begin
                        data_q <= {data_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= '0;
                end
                MODE_HOLD: begin
                    data_q <= data_q;
                end
                default: begin
                    data_q <= data_q;
                end
            endcase
        end
    end

    // Serial output taps the leading bit so the first shift-out bit is visible before any edge.
    assign o_serial     = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
    assign o_parallel   = data_q;
    assign o_word_valid = word_vld_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: one MSB-first and one LSB-first instance driven by the same directed stimulus.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       ser;
    logic [7:0] par;

    logic       s0, s1, v0, v1;
    logic [7:0] p0, p1;

    int vectors = 0;
    int fails   = 0;
    int pulses0 = 0;
    int pulses1 = 0;

    typedef struct packed {
        logic [7:0] p0;
        logic       s0;
        logic       v0;
        logic [7:0] p1;
        logic       s1;
        logic       v1;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mq0, mq1;
    int         mc0, mc1;
    logic       mv0, mv1;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .i_mode(mode), .i_serial(ser), .i_parallel(par),
        .o_serial(s0), .o_parallel(p0), .o_word_valid(v0)
    );

    universal_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .i_mode(mode), .i_serial(ser), .i_parallel(par),
        .o_serial(s1), .o_parallel(p1), .o_word_valid(v1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit lsb, input logic r, input logic [1:0] md, input logic s,
                         input logic [7:0] pw, inout logic [7:0] q, inout int c, inout logic v);
        if (r) begin
            q = 8'h00; c = 0; v = 1'b0;
        end else begin
            v = 1'b0;
            case (md)
                2'b01: begin
                    q = lsb ? {s, q[7:1]} : {q[6:0], s};
                    if (c == 7) begin
                        c = 0; v = 1'b1;
                    end else begin
                        c = c + 1;
                    end
                end
                2'b10: begin q = pw; c = 0; end
                2'b11: begin q = lsb ? {1'b0, q[7:1]} : {q[6:0], 1'b0}; c = 0; end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle, push the model's expectation, then compare the popped entry after the edge.
    task automatic step(input logic r, input logic [1:0] md, input logic s, input logic [7:0] pw);
        exp_t e;
        rst = r; mode = md; ser = s; par = pw;
        model(1'b0, r, md, s, pw, mq0, mc0, mv0);
        model(1'b1, r, md, s, pw, mq1, mc1, mv1);
        e.p0 = mq0; e.s0 = mq0[7]; e.v0 = mv0;
        e.p1 = mq1; e.s1 = mq1[0]; e.v1 = mv1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("msb_parallel", {24'h0, p0}, {24'h0, e.p0});
        chk("msb_serial",   {31'h0, s0}, {31'h0, e.s0});
        chk("msb_valid",    {31'h0, v0}, {31'h0, e.v0});
        chk("lsb_parallel", {24'h0, p1}, {24'h0, e.p1});
        chk("lsb_serial",   {31'h0, s1}, {31'h0, e.s1});
        chk("lsb_valid",    {31'h0, v1}, {31'h0, e.v1});
        if (v0 === 1'b1) pulses0++;
        if (v1 === 1'b1) pulses1++;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] a5_bits;
        logic [7:0] held;
        mq0 = 8'h00; mq1 = 8'h00; mc0 = 0; mc1 = 0; mv0 = 1'b0; mv1 = 1'b0;
        rst = 1'b1; mode = 2'b01; ser = 1'b1; par = 8'hFF;
        @(posedge clk);
        #1;

        // Reset overrides SHIFT_IN with serial=1.
        step(1'b1, 2'b01, 1'b1, 8'hFF);
        step(1'b1, 2'b01, 1'b1, 8'hFF);
        chk("rst_parallel", {24'h0, p0}, 32'h0);
        chk("rst_serial",   {31'h0, s0}, 32'h0);
        chk("rst_valid",    {31'h0, v0}, 32'h0);
        chk("rst_lsb_par",  {24'h0, p1}, 32'h0);

        // MSB-first word 0xB3, then 0x5A back-to-back.
        w = 8'hB3;
        pulses0 = 0;
        for (int i = 7; i >= 0; i--) step(1'b0, 2'b01, w[i], 8'h00);
        chk("b3_word",  {24'h0, p0}, 32'hB3);
        chk("b3_pulse", {31'h0, v0}, 32'h1);
        w = 8'h5A;
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 2'b01, w[i], 8'h00);
            if (i == 7) chk("b2b_no_pulse", {31'h0, v0}, 32'h0);
        end
        chk("5a_word",   {24'h0, p0}, 32'h5A);
        chk("5a_pulse",  {31'h0, v0}, 32'h1);
        chk("b2b_count", pulses0, 2);

        // LSB-first: bits 1,1,0,0,1,1,0,1 assemble 0xB3.
        w = 8'hB3;
        pulses1 = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 2'b01, w[i], 8'h00);
        chk("lsb_b3_word",  {24'h0, p1}, 32'hB3);
        chk("lsb_b3_count", pulses1, 1);

        // LOAD 0xA5 then shift out MSB-first.
        a5_bits = 8'hA5;
        pulses0 = 0;
        step(1'b0, 2'b10, 1'b0, 8'hA5);
        for (int k = 0; k < 8; k++) begin
            chk("a5_serial_bit", {31'h0, s0}, {31'h0, a5_bits[7-k]});
            step(1'b0, 2'b11, 1'b1, 8'h00);
        end
        chk("a5_empty",    {24'h0, p0}, 32'h0);
        chk("a5_no_pulse", pulses0, 0);

        // Word split by HOLD.
        w = 8'hC9;
        pulses0 = 0;
        for (int i = 7; i >= 3; i--) step(1'b0, 2'b01, w[i], 8'h00);
        held = p0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 1'b1, 8'hFF);
            chk("hold_stable", {24'h0, p0}, {24'h0, held});
        end
        chk("hold_no_pulse", pulses0, 0);
        for (int i = 2; i >= 0; i--) step(1'b0, 2'b01, w[i], 8'h00);
        chk("hold_word",  {24'h0, p0}, 32'hC9);
        chk("hold_pulse", {31'h0, v0}, 32'h1);
        chk("hold_count", pulses0, 1);

        // Partial word discarded by LOAD.
        pulses0 = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 1'b1, 8'h00);
        step(1'b0, 2'b10, 1'b0, 8'h3C);
        for (int i = 0; i < 7; i++) step(1'b0, 2'b01, 1'b0, 8'h00);
        chk("load_discard", pulses0, 0);
        step(1'b0, 2'b01, 1'b1, 8'h00);
        chk("load_8th_pulse", {31'h0, v0}, 32'h1);

        // Partial word discarded by a one-cycle reset.
        pulses0 = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 1'b1, 8'h00);
        step(1'b1, 2'b01, 1'b1, 8'hFF);
        chk("midrst_clear", {24'h0, p0}, 32'h0);
        for (int i = 0; i < 7; i++) step(1'b0, 2'b01, 1'b1, 8'h00);
        chk("rst_discard", pulses0, 0);
        step(1'b0, 2'b01, 1'b1, 8'h00);
        chk("rst_8th_pulse", {31'h0, v0}, 32'h1);
        chk("rst_8th_word",  {24'h0, p0}, 32'hFF);
        step(1'b0, 2'b00, 1'b0, 8'h00);
        chk("pulse_one_cycle", {31'h0, v0}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
